bit_serial_add_ctrl: RTL and testbench

Sequencing controller that time-multiplexes a single 1-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first. It accepts operands on a start pulse, shifts them through the cell while holding the ripple carry in a flop, and presents a registered sum, carry-out and signed overflow with a one-cycle done strobe. It sits between a requesting datapath and the shared adder cell, trading latency for area.

---
 rtl/bit_serial_pkg.sv | 12 +
 rtl/bit_serial_add_ctrl_if.sv | 28 ++
 rtl/bit_serial_add_ctrl_fa_cell.sv | 16 +
 rtl/bit_serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package bit_serial_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : bit_serial_pkg

// File: rtl/bit_serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the serial adder (slave).
interface bit_serial_add_ctrl_if
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface : bit_serial_add_ctrl_if

// File: rtl/bit_serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder shared across all bit positions of the serial add.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ cin;
  assign c   = (a & b) | (cin & w_p);

endmodule : fa_cell

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH cycles,
// with registered sum/carry/overflow and a one-cycle done strobe.
module bit_serial_add_ctrl
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             r_state;
  state_e             w_state_nxt;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_sum_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_s;
  logic               w_c;
  logic               w_load;
  logic               w_run;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_sh;

  fa_cell u_fa_cell (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .cin (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  // start is only honoured when the cell is free; requests during RUN are dropped.
  assign w_load   = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == LAST_BIT);
  assign w_sum_sh = {w_s, r_sum_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_BIT) w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == RUN);
    bus.done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_carry  <= bus.cin;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_sum_sr <= w_sum_sh[WIDTH-1:1];
      r_carry  <= w_c;
      r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Results move only on the final-bit edge so the requester sees a stable prior value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_sum_sh;
      r_cout <= w_c;
      r_ovf  <= r_carry ^ w_c;
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule : bit_serial_add_ctrl

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl: directed vector table, corner sequences, random ops.
module tb_bit_serial_add_ctrl;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bit_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov);
    int unsigned u;
    int          sa;
    int          lim;
    u   = int'(a) + int'(b) + int'(cin);
    s   = W'(u % (1 << W));
    co  = (u >= (1 << W));
    sa  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    lim = 1 << (W - 1);
    ov  = (sa >= lim) || (sa < -lim);
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // cyc counts clock edges since acceptance; done must be seen when cyc reaches W.
  task automatic watch(input int glitch_at, input logic [W-1:0] prev,
                       output int cyc, output int hold_bad, output int busy_bad, output int both_bad);
    cyc = 0; hold_bad = 0; busy_bad = 0; both_bad = 0;
    while (!bus.done && cyc < TIMEOUT) begin
      if (bus.busy && bus.done) both_bad++;
      if (!bus.busy) busy_bad++;
      if (bus.sum !== prev) hold_bad++;
      if (cyc == glitch_at) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (bus.busy && bus.done) both_bad++;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_sum"},  bus.sum,  es);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"},  bus.ovf,  eo);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int glitch_at, input string tag);
    logic [W-1:0] prev, es;
    logic         ec, eo;
    int           cyc, hold_bad, busy_bad, both_bad;
    prev = bus.sum;
    model(a, b, cin, es, ec, eo);
    launch(a, b, cin);
    watch(glitch_at, prev, cyc, hold_bad, busy_bad, both_bad);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_sum_hold"}, hold_bad, 0);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_busy_done_overlap"}, both_bad, 0);
    check_result(tag, es, ec, eo);
    @(negedge clk);
    check({tag, "_done_strobe"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec, eo;
    int           cyc, hold_bad, busy_bad, both_bad;

    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sum: 8'h8D, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum",  bus.sum,  '0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf",  bus.ovf,  1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_done", bus.done, 1'b0);
    check("post_rst_busy", bus.busy, 1'b0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      watch(-1, bus.sum, cyc, hold_bad, busy_bad, both_bad);
      check($sformatf("vec%0d_latency", i), cyc, W);
      check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d_done_strobe", i), bus.done, 1'b0);
    end

    // Busy protection: extra start mid-RUN must be dropped
    do_op(8'h5A, 8'h33, 1'b0, 3, "busy_prot");
    do_op(8'h12, 8'h34, 1'b1, W - 1, "busy_prot_last");

    // Back-to-back: start held through DONE, no IDLE cycle in between
    launch(8'h5A, 8'h33, 1'b0);
    watch(-1, bus.sum, cyc, hold_bad, busy_bad, both_bad);
    check("b2b_first_sum", bus.sum, 8'h8D);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_idle_busy", bus.busy, 1'b1);
    check("b2b_no_idle_done", bus.done, 1'b0);
    watch(-1, 8'h8D, cyc, hold_bad, busy_bad, both_bad);
    check("b2b_gap_from_done", cyc + 1, W + 1);
    check("b2b_hold", hold_bad, 0);
    check("b2b_sum",  bus.sum,  8'h30);
    check("b2b_cout", bus.cout, 1'b0);
    @(negedge clk);
    check("b2b_done_strobe", bus.done, 1'b0);

    // Reset mid-op: asynchronous clear, then a clean operation
    launch(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_sum",  bus.sum,  '0);
    check("midrst_cout", bus.cout, 1'b0);
    check("midrst_ovf",  bus.ovf,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle_busy", bus.busy, 1'b0);
    check("midrst_idle_done", bus.done, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, -1, "after_midrst");

    // Randomized operations against the model
    for (int k = 0; k < 40; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1,
            $sformatf("rnd%0d", k));
    end

    model(8'h5A, 8'h33, 1'b0, es, ec, eo);
    check("model_sanity_sum", es, 8'h8D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bit_serial_add_ctrl
